// File: rtl/line_burst_adapter.sv
// Cache-line responder: turns one 256-bit line read/write into a fixed
// 4-beat, 64-bit burst on the memory side and pulses line_resp_o when done.
module line_burst_adapter #(
  parameter int LINE_W   = 256,
  parameter int BEAT_W   = 64,
  parameter int BEATS    = 4,
  parameter int OFFSET_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_read_i,
  input  logic              line_write_i,
  input  logic [31:0]       line_addr_i,
  input  logic [LINE_W-1:0] line_wdata_i,
  output logic [LINE_W-1:0] line_rdata_o,
  output logic              line_resp_o,
  output logic              burst_read_o,
  output logic              burst_write_o,
  output logic [31:0]       burst_addr_o,
  output logic [BEAT_W-1:0] burst_wdata_o,
  input  logic [BEAT_W-1:0] burst_rdata_i,
  input  logic              burst_resp_i
);

  localparam int              CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [31:0]     ADDR_MASK = ~((32'd1 << OFFSET_W) - 32'd1);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  // Shared line buffer: holds write data for writes, assembles beats for reads.
  logic [LINE_W-1:0]  line_q, line_d;
  logic [LINE_W-1:0]  rdata_q, rdata_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (line_read_i || line_write_i) begin
          addr_d  = line_addr_i & ADDR_MASK;
          line_d  = line_wdata_i;
          cnt_d   = '0;
          state_d = line_read_i ? RD_BURST : WR_BURST;
        end
      end
      RD_BURST: begin
        if (burst_resp_i) begin
          line_d[BEAT_W*cnt_q +: BEAT_W] = burst_rdata_i;
          cnt_d = cnt_q + 1'b1;
          // Publish the whole line at once so line_rdata_o stays stable mid-burst.
          if (cnt_q == LAST_BEAT) begin
            rdata_d = line_d;
            state_d = DONE;
          end
        end
      end
      WR_BURST: begin
        if (burst_resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; always_comb above uses blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
    end
  end

  assign burst_read_o  = (state_q == RD_BURST);
  assign burst_write_o = (state_q == WR_BURST);
  assign line_resp_o   = (state_q == DONE);
  assign burst_addr_o  = addr_q;
  assign burst_wdata_o = (state_q == WR_BURST) ? line_q[BEAT_W*cnt_q +: BEAT_W] : '0;
  assign line_rdata_o  = rdata_q;

endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed self-checking bench for line_burst_adapter: reads, gapped writes,
// back-to-back traffic, mid-burst reset, spurious and simultaneous requests.
module tb_line_burst_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_read, line_write;
  logic [31:0]  line_addr;
  logic [255:0] line_wdata, line_rdata;
  logic         line_resp, burst_read, burst_write;
  logic [31:0]  burst_addr;
  logic [63:0]  burst_wdata, burst_rdata;
  logic         burst_resp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_burst_adapter dut (
    .clk           (clk),
    .rst           (rst),
    .line_read_i   (line_read),
    .line_write_i  (line_write),
    .line_addr_i   (line_addr),
    .line_wdata_i  (line_wdata),
    .line_rdata_o  (line_rdata),
    .line_resp_o   (line_resp),
    .burst_read_o  (burst_read),
    .burst_write_o (burst_write),
    .burst_addr_o  (burst_addr),
    .burst_wdata_o (burst_wdata),
    .burst_rdata_i (burst_rdata),
    .burst_resp_i  (burst_resp)
  );

  always @(posedge clk)
    if (!rst && line_read && line_write)
      $warning("simultaneous line read and write request");

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full read with four gap-free beats, issued from an IDLE cycle.
  task automatic read_txn(input logic [31:0] addr, input logic [31:0] exp_addr,
                          input logic [255:0] line, input logic also_write,
                          input logic [255:0] old_rdata);
    logic [255:0] l;
    l = line;
    line_read  = 1'b1;
    line_write = also_write;
    line_addr  = addr;
    tick();
    line_read  = 1'b0;
    line_write = 1'b0;
    line_addr  = 32'hFFFF_FFFF;
    check("rd_req", burst_read, 1'b1);
    check("rd_no_wr", burst_write, 1'b0);
    check("rd_addr", burst_addr, exp_addr);
    burst_resp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      burst_rdata = l[64*i +: 64];
      check("rd_hold", line_rdata, old_rdata);
      check("rd_no_resp", line_resp, 1'b0);
      check("rd_addr_stable", burst_addr, exp_addr);
      tick();
    end
    burst_resp  = 1'b0;
    burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    check("rd_resp", line_resp, 1'b1);
    check("rd_drop", burst_read, 1'b0);
    check("rd_data", line_rdata, line);
    tick();
    check("rd_pulse", line_resp, 1'b0);
    check("rd_idle", burst_read, 1'b0);
  endtask

  localparam logic [255:0] RD1 = {64'h4444444444444444, 64'h3333333333333333,
                                  64'h2222222222222222, 64'h1111111111111111};
  localparam logic [255:0] RD2 = {64'hA3A3A3A3A3A3A3A3, 64'hA2A2A2A2A2A2A2A2,
                                  64'hA1A1A1A1A1A1A1A1, 64'hA0A0A0A0A0A0A0A0};
  localparam logic [255:0] RD3 = {64'hC0FFEE00C0FFEE03, 64'hC0FFEE00C0FFEE02,
                                  64'hC0FFEE00C0FFEE01, 64'hC0FFEE00C0FFEE00};
  localparam logic [255:0] RD4 = {64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0,
                                  64'h5A5A5A5A5A5A5A5A, 64'hA5A5A5A5A5A5A5A5};
  localparam logic [255:0] WR1 = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                                  64'h89ABCDEF01234567, 64'h76543210FEDCBA98};

  initial begin
    logic [63:0]  wbeat [4];
    logic [6:0]   pat;
    int           wexp;

    rst         = 1'b1;
    line_read   = 1'b0;
    line_write  = 1'b0;
    line_addr   = '0;
    line_wdata  = '0;
    burst_rdata = '0;
    burst_resp  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_resp", line_resp, 1'b0);
    check("rst_read", burst_read, 1'b0);
    check("rst_write", burst_write, 1'b0);
    check("rst_addr", burst_addr, 32'h0);
    check("rst_wdata", burst_wdata, 64'h0);
    check("rst_rdata", line_rdata, 256'h0);

    // Read, no gaps: request at cycle 0, beats cycles 1-4, resp at cycle 5.
    read_txn(32'h0000_1234, 32'h0000_1220, RD1, 1'b0, 256'h0);

    // Write with resp pattern 1,0,1,0,0,1,1.
    wbeat[0] = 64'h76543210FEDCBA98;
    wbeat[1] = 64'h89ABCDEF01234567;
    wbeat[2] = 64'hFEDCBA9876543210;
    wbeat[3] = 64'h0123456789ABCDEF;
    pat  = 7'b1100101;  // applied LSB first
    wexp = 0;
    line_write = 1'b1;
    line_addr  = 32'h0000_5FFF;
    line_wdata = WR1;
    tick();
    line_write = 1'b0;
    line_wdata = '1;
    check("wr_addr", burst_addr, 32'h0000_5FE0);
    for (int i = 0; i < 7; i++) begin
      burst_resp = pat[i];
      check("wr_req", burst_write, 1'b1);
      check("wr_no_rd", burst_read, 1'b0);
      check("wr_beat", burst_wdata, wbeat[wexp]);
      check("wr_no_resp", line_resp, 1'b0);
      tick();
      if (pat[i]) wexp++;
    end
    burst_resp = 1'b0;
    check("wr_resp", line_resp, 1'b1);
    check("wr_drop", burst_write, 1'b0);
    check("wr_rdata_kept", line_rdata, RD1);
    tick();
    check("wr_pulse", line_resp, 1'b0);

    // Back-to-back: this IDLE cycle is the only gap before burst_read_o.
    read_txn(32'h8000_107F, 32'h8000_1060, RD2, 1'b0, RD1);

    // Reset after two read beats.
    line_read = 1'b1;
    line_addr = 32'h0000_0040;
    tick();
    line_read  = 1'b0;
    burst_resp = 1'b1;
    burst_rdata = 64'h9999999999999999;
    tick();
    burst_rdata = 64'h8888888888888888;
    tick();
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    burst_resp = 1'b0;
    check("abort_read", burst_read, 1'b0);
    check("abort_resp", line_resp, 1'b0);
    check("abort_rdata", line_rdata, 256'h0);
    check("abort_addr", burst_addr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_resp", line_resp, 1'b0);
    end
    read_txn(32'h0001_0008, 32'h0001_0000, RD3, 1'b0, 256'h0);

    // Spurious burst_resp_i in IDLE changes nothing.
    burst_resp  = 1'b1;
    burst_rdata = 64'h7777777777777777;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("spur_read", burst_read, 1'b0);
      check("spur_write", burst_write, 1'b0);
      check("spur_resp", line_resp, 1'b0);
      check("spur_rdata", line_rdata, RD3);
    end
    burst_resp = 1'b0;

    // Simultaneous read and write: read wins.
    read_txn(32'hFFFF_FFE1, 32'hFFFF_FFE0, RD4, 1'b1, RD3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
